// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: arbitrates, latches operands,
// runs one EXEC cycle, then holds the registered result until the winner consumes it.
module alu_arbiter #(
  parameter bit PRIO_RR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic        grant_q;
  logic        last_grant_q;
  logic        busy_q;
  logic [1:0]  rsp_valid_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic [31:0] result_q;
  logic        zero_q;

  logic        grant_d;
  logic        accept;
  logic        rsp_ready_g;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_d = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_d = PRIO_RR ? ~last_grant_q : 1'b0;
    end else if (req1_valid) begin
      grant_d = 1'b1;
    end
  end

  assign accept      = (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready  = accept && !grant_d;
  assign req1_ready  = accept && grant_d;
  assign rsp_ready_g = grant_q ? rsp1_ready : rsp0_ready;

  // NOTE: state registers use non-blocking (<=) so all of them update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= EXEC;
            busy_q       <= 1'b1;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            a_q          <= grant_d ? req1_a  : req0_a;
            b_q          <= grant_d ? req1_b  : req0_b;
            op_q         <= grant_d ? req1_op : req0_op;
          end
        end
        EXEC: begin
          state_q     <= RESP;
          result_q    <= alu_result;
          zero_q      <= alu_zero;
          rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
        end
        RESP: begin
          // Only the winner's ready matters; the other response port is never valid here.
          if (rsp_ready_g) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rsp_valid_q <= 2'b00;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (pending requests, last grant, ALU arithmetic).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [2:0]  req_op [2];
  logic [1:0]  rsp_ready;
  logic [1:0]  fp_rsp_ready;

  logic [1:0]  rr_req_ready, rr_rsp_valid, rr_rsp_zero;
  logic [31:0] rr_rsp_result [2];
  logic [31:0] rr_alu_a, rr_alu_b, rr_alu_result;
  logic [2:0]  rr_alu_op;
  logic        rr_alu_zero, rr_busy;

  logic [1:0]  fp_req_ready, fp_rsp_valid, fp_rsp_zero;
  logic [31:0] fp_rsp_result [2];
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result;
  logic [2:0]  fp_alu_op;
  logic        fp_alu_zero, fp_busy;

  int n_vec = 0;
  int n_err = 0;

  bit          pend [2];
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  logic [2:0]  pop [2];
  bit          model_last;
  bit          rand_mode;
  int          cur_g;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[4:0];
      3'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  // External ALU seen by each DUT.
  assign rr_alu_result = alu_ref(rr_alu_a, rr_alu_b, rr_alu_op);
  assign rr_alu_zero   = (rr_alu_result == 32'd0);
  assign fp_alu_result = alu_ref(fp_alu_a, fp_alu_b, fp_alu_op);
  assign fp_alu_zero   = (fp_alu_result == 32'd0);

  alu_arbiter #(.PRIO_RR(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(rr_req_ready[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
    .req1_valid(req_valid[1]), .req1_ready(rr_req_ready[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
    .rsp0_valid(rr_rsp_valid[0]), .rsp0_ready(rsp_ready[0]),
    .rsp0_result(rr_rsp_result[0]), .rsp0_zero(rr_rsp_zero[0]),
    .rsp1_valid(rr_rsp_valid[1]), .rsp1_ready(rsp_ready[1]),
    .rsp1_result(rr_rsp_result[1]), .rsp1_zero(rr_rsp_zero[1]),
    .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_op(rr_alu_op),
    .alu_result(rr_alu_result), .alu_zero(rr_alu_zero),
    .busy(rr_busy)
  );

  alu_arbiter #(.PRIO_RR(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_ready(fp_req_ready[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_op(req_op[0]),
    .req1_valid(req_valid[1]), .req1_ready(fp_req_ready[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_op(req_op[1]),
    .rsp0_valid(fp_rsp_valid[0]), .rsp0_ready(fp_rsp_ready[0]),
    .rsp0_result(fp_rsp_result[0]), .rsp0_zero(fp_rsp_zero[0]),
    .rsp1_valid(fp_rsp_valid[1]), .rsp1_ready(fp_rsp_ready[1]),
    .rsp1_result(fp_rsp_result[1]), .rsp1_zero(fp_rsp_zero[1]),
    .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_op(fp_alu_op),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero),
    .busy(fp_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = pend[i];
      req_a[i]     = pend[i] ? pa[i]  : $urandom;
      req_b[i]     = pend[i] ? pb[i]  : $urandom;
      req_op[i]    = pend[i] ? pop[i] : 3'($urandom_range(0, 7));
    end
  endtask

  task automatic new_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pend[i] = 1'b1;
    pop[i]  = op;
    pa[i]   = a;
    pb[i]   = b;
  endtask

  task automatic rand_req(input int i);
    logic [31:0] a;
    a = $urandom;
    new_req(i, 3'($urandom_range(0, 7)), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
  endtask

  // Advance one clock; inputs change and outputs are sampled well clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) rand_req(i);
      end
      rsp_ready[1 - cur_g] = 1'($urandom_range(0, 1));
    end
    drive();
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pend[0]   = 1'b0;
    pend[1]   = 1'b0;
    rsp_ready = 2'b00;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    model_last = 1'b1;
    #1;
  endtask

  // Runs one whole operation from the current IDLE cycle; leaves the bench in the next IDLE cycle.
  task automatic serve(input int stall, output int g);
    logic [31:0] ea, er;
    logic        ez;
    if (pend[0] && pend[1]) g = model_last ? 0 : 1;
    else                    g = pend[1] ? 1 : 0;
    cur_g = g;
    check("idle_ready0", rr_req_ready[0], g == 0);
    check("idle_ready1", rr_req_ready[1], g == 1);
    check("idle_busy", rr_busy, 0);
    ea = pa[g];
    er = alu_ref(pa[g], pb[g], pop[g]);
    ez = (er == 32'd0);
    pend[g]    = 1'b0;
    model_last = g[0];
    step();
    check("exec_ready", rr_req_ready, 0);
    check("exec_busy", rr_busy, 1);
    check("exec_rsp_valid", rr_rsp_valid, 0);
    check("exec_alu_a", rr_alu_a, ea);
    step();
    for (int s = 0; s <= stall; s++) begin
      check("resp_valid_g", rr_rsp_valid[g], 1);
      check("resp_valid_other", rr_rsp_valid[1 - g], 0);
      check("resp_result", rr_rsp_result[g], er);
      check("resp_result_other", rr_rsp_result[1 - g], er);
      check("resp_zero", rr_rsp_zero[g], ez);
      check("resp_ready", rr_req_ready, 0);
      check("resp_busy", rr_busy, 1);
      rsp_ready[g] = (s == stall);
      step();
    end
    rsp_ready[g] = 1'b0;
    check("release_busy", rr_busy, 0);
    check("release_valid", rr_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int rr_q[$];
    int fp_q[$];
    rand_mode    = 1'b0;
    cur_g        = 0;
    fp_rsp_ready = 2'b11;
    do_reset();

    check("rst_alu_a", rr_alu_a, 0);
    check("rst_alu_b", rr_alu_b, 0);
    check("rst_alu_op", rr_alu_op, 0);
    check("rst_result0", rr_rsp_result[0], 0);
    check("rst_result1", rr_rsp_result[1], 0);
    check("rst_zero", rr_rsp_zero, 0);
    check("rst_valid", rr_rsp_valid, 0);
    check("rst_busy", rr_busy, 0);
    check("rst_ready", rr_req_ready, 0);

    // Lone add: ready in cycle 0, response from cycle 2.
    new_req(0, 3'd0, 32'd5, 32'd7);
    drive();
    #1;
    check("t028_ready0", rr_req_ready[0], 1);
    serve(0, g);
    check("t028_grant", g, 0);
    check("t028_result", rr_rsp_result[0], 32'd12);
    check("t028_zero", rr_rsp_zero[0], 0);

    // Contested first cycle after reset goes to requester 0.
    do_reset();
    new_req(0, 3'd1, 32'd9, 32'd9);
    new_req(1, 3'd6, 32'h0000_00F0, 32'h0000_000F);
    drive();
    #1;
    serve(0, g);
    check("t029_first", g, 0);
    check("t029_result0", rr_rsp_result[0], 32'd0);
    check("t029_zero0", rr_rsp_zero[0], 1);
    serve(0, g);
    check("t029_second", g, 1);
    check("t029_result1", rr_rsp_result[1], 32'h0000_00FF);
    check("t029_zero1", rr_rsp_zero[1], 0);

    // Both held valid: round-robin alternates, fixed priority always picks 0.
    do_reset();
    new_req(0, 3'd4, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    new_req(1, 3'd7, 32'hFFFF_0000, 32'h1234_5678);
    rsp_ready = 2'b11;
    drive();
    #1;
    for (int c = 0; c < 40 && (rr_q.size() < 4 || fp_q.size() < 4); c++) begin
      if (rr_req_ready != 2'b00 && rr_q.size() < 4) rr_q.push_back(int'(rr_req_ready[1]));
      if (fp_req_ready != 2'b00 && fp_q.size() < 4) fp_q.push_back(int'(fp_req_ready[1]));
      step();
    end
    check("t030_rr_count", rr_q.size(), 4);
    check("t030_fp_count", fp_q.size(), 4);
    for (int i = 0; i < rr_q.size(); i++) check("t030_rr_order", rr_q[i], i % 2);
    for (int i = 0; i < fp_q.size(); i++) check("t030_fp_order", fp_q[i], 0);

    // Back-pressure on requester 0 with requester 1 waiting.
    do_reset();
    new_req(0, 3'd0, 32'hFFFF_FFFF, 32'd3);
    new_req(1, 3'd3, 32'hFFFF_FFFE, 32'd1);
    drive();
    #1;
    serve(5, g);
    check("t031_grant", g, 0);
    check("t031_result", rr_rsp_result[0], 32'd2);
    serve(0, g);
    check("t031_next", g, 1);
    check("t031_slt", rr_rsp_result[1], 32'd1);

    // Reset during EXEC drops the operation.
    do_reset();
    new_req(1, 3'd2, 32'd1, 32'd4);
    drive();
    #1;
    check("t032_accept", rr_req_ready[1], 1);
    pend[1] = 1'b0;
    step();
    check("t032_exec_busy", rr_busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t032_busy", rr_busy, 0);
    check("t032_alu_a", rr_alu_a, 0);
    check("t032_valid", rr_rsp_valid[1], 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t032_no_rsp", rr_rsp_valid[1], 0);
    end
    new_req(1, 3'd2, 32'd1, 32'd4);
    drive();
    #1;
    serve(0, g);
    check("t032_grant", g, 1);
    check("t032_result", rr_rsp_result[1], 32'd16);

    // Randomized traffic.
    do_reset();
    rand_mode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (!pend[0] && !pend[1]) begin
        case ($urandom_range(0, 2))
          0:       rand_req(0);
          1:       rand_req(1);
          default: begin rand_req(0); rand_req(1); end
        endcase
      end
      drive();
      #1;
      serve(int'($urandom_range(0, 3)), g);
    end
    rand_mode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
